// File: rtl/osc_meas_scheduler.sv
// Round-robin scheduler sharing one gated timer counter among NCH
// oscillator-measurement requesters. Per measurement: grant a channel,
// clear the counter, open the gate for wlen REF_CLK cycles, wait SETTLE
// cycles for the SYSCLK-side count to settle, then report completion.
// Counter controls and DONE are registered from the current state, so they
// appear one cycle after the state is entered; an abort overrides them on
// the abort edge itself so the gate closes immediately.
module osc_meas_scheduler #(
  parameter int NCH    = 4,
  parameter int CH_W   = 2,
  parameter int SETTLE = 3
) (
  input  logic            REF_CLK,
  input  logic            OPB_RST,
  input  logic [NCH-1:0]  REQ,
  input  logic [15:0]     WINDOW,
  input  logic            ABORT,
  output logic [NCH-1:0]  GNT,
  output logic [CH_W-1:0] CH_SEL,
  output logic            CNT_CLR,
  output logic            CNT_GATE,
  output logic            BUSY,
  output logic            DONE,
  output logic [CH_W-1:0] DONE_CH,
  output logic            ABORTED
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_GATE   = 3'd2,
    S_SETTLE = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NCH - 1);
  localparam logic [CH_W:0]   NCH_L   = (CH_W + 1)'(NCH);
  localparam logic [15:0]     SETTLE_L = 16'(SETTLE);

  state_t          state_q, state_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [15:0]     wlen_q, wlen_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [NCH-1:0]  gnt_q, gnt_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            clr_q, clr_d;
  logic            gate_q, gate_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [CH_W-1:0] done_ch_q, done_ch_d;
  logic            aborted_q, aborted_d;

  logic            pick_vld_s;
  logic [CH_W-1:0] pick_ch_s;
  logic [CH_W:0]   idx_s;
  logic            abort_hit_s;

  // Channel following c, wrapping after the last requester.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    if (c == CH_LAST) begin
      return {CH_W{1'b0}};
    end else begin
      return c + {{(CH_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Round-robin search: first requesting channel at or above the pointer, modulo NCH.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_ch_s  = {CH_W{1'b0}};
    idx_s      = {(CH_W+1){1'b0}};
    for (int i = 0; i < NCH; i++) begin
      idx_s = {1'b0, ptr_q} + i[CH_W:0];
      if (idx_s >= NCH_L) begin
        idx_s = idx_s - NCH_L;
      end else begin
        idx_s = idx_s;
      end
      if (!pick_vld_s && REQ[idx_s[CH_W-1:0]]) begin
        pick_vld_s = 1'b1;
        pick_ch_s  = idx_s[CH_W-1:0];
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  assign abort_hit_s = ABORT && ((state_q == S_CLEAR) || (state_q == S_GATE) ||
                                 (state_q == S_SETTLE));

  // Next-state and next-output decode; abort takes priority over normal sequencing.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wlen_d    = wlen_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    ch_d      = ch_q;
    clr_d     = 1'b0;
    gate_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_ch_d = done_ch_q;
    aborted_d = 1'b0;
    if (abort_hit_s) begin
      state_d   = S_IDLE;
      gnt_d     = {NCH{1'b0}};
      busy_d    = 1'b0;
      aborted_d = 1'b1;
      ptr_d     = next_ch(ch_q);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld_s) begin
            state_d = S_CLEAR;
            ch_d    = pick_ch_s;
            gnt_d   = {{(NCH-1){1'b0}}, 1'b1} << pick_ch_s;
            busy_d  = 1'b1;
            wlen_d  = (WINDOW == 16'd0) ? 16'd1 : WINDOW;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CLEAR: begin
          clr_d   = 1'b1;
          cnt_d   = wlen_q;
          state_d = S_GATE;
        end
        S_GATE: begin
          gate_d = 1'b1;
          if (cnt_q == 16'd1) begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_L;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        S_SETTLE: begin
          if (cnt_q == 16'd1) begin
            state_d = S_REPORT;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        S_REPORT: begin
          done_d    = 1'b1;
          done_ch_d = ch_q;
          ptr_d     = next_ch(ch_q);
          gnt_d     = {NCH{1'b0}};
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          gnt_d   = {NCH{1'b0}};
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge REF_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state_q   <= S_IDLE;
      ptr_q     <= {CH_W{1'b0}};
      wlen_q    <= 16'd1;
      cnt_q     <= 16'd0;
      gnt_q     <= {NCH{1'b0}};
      ch_q      <= {CH_W{1'b0}};
      clr_q     <= 1'b0;
      gate_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_ch_q <= {CH_W{1'b0}};
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wlen_q    <= wlen_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      ch_q      <= ch_d;
      clr_q     <= clr_d;
      gate_q    <= gate_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_ch_q <= done_ch_d;
      aborted_q <= aborted_d;
    end
  end

  assign GNT      = gnt_q;
  assign CH_SEL   = ch_q;
  assign CNT_CLR  = clr_q;
  assign CNT_GATE = gate_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign DONE_CH  = done_ch_q;
  assign ABORTED  = aborted_q;

endmodule

// File: tb/tb_osc_meas_scheduler.sv
// Directed bench for osc_meas_scheduler: a table of single measurements
// plus hand-written sequences for round robin, abort and mid-gate reset.
module tb_osc_meas_scheduler;
  localparam int NCH    = 4;
  localparam int CH_W   = 2;
  localparam int SETTLE = 3;

  logic            REF_CLK = 1'b0;
  logic            OPB_RST;
  logic [NCH-1:0]  REQ;
  logic [15:0]     WINDOW;
  logic            ABORT;
  logic [NCH-1:0]  GNT;
  logic [CH_W-1:0] CH_SEL;
  logic            CNT_CLR, CNT_GATE, BUSY, DONE, ABORTED;
  logic [CH_W-1:0] DONE_CH;

  int checks = 0;
  int errors = 0;

  osc_meas_scheduler #(.NCH(NCH), .CH_W(CH_W), .SETTLE(SETTLE)) dut (
    .REF_CLK(REF_CLK), .OPB_RST(OPB_RST), .REQ(REQ), .WINDOW(WINDOW),
    .ABORT(ABORT), .GNT(GNT), .CH_SEL(CH_SEL), .CNT_CLR(CNT_CLR),
    .CNT_GATE(CNT_GATE), .BUSY(BUSY), .DONE(DONE), .DONE_CH(DONE_CH),
    .ABORTED(ABORTED)
  );

  always #5 REF_CLK = ~REF_CLK;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] win;
    logic [15:0] win_after;
    logic [1:0]  ch;
    int          gate;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"},     32'(GNT), 32'd0);
    chk({tag, "_ch_sel"},  32'(CH_SEL), 32'd0);
    chk({tag, "_cnt_clr"}, 32'(CNT_CLR), 32'd0);
    chk({tag, "_gate"},    32'(CNT_GATE), 32'd0);
    chk({tag, "_busy"},    32'(BUSY), 32'd0);
    chk({tag, "_done"},    32'(DONE), 32'd0);
    chk({tag, "_done_ch"}, 32'(DONE_CH), 32'd0);
    chk({tag, "_aborted"}, 32'(ABORTED), 32'd0);
  endtask

  // Called at the sample phase while idle; grant must appear on the next edge.
  task automatic do_grant(input logic [3:0] req, input logic [15:0] win,
                          input logic [15:0] win_after, input logic [1:0] ch,
                          input bit hold);
    int w;
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    REQ = req;
    WINDOW = win;
    w = 0;
    do begin
      @(posedge REF_CLK); #1;
      w++;
    end while (!BUSY && w < 8);
    chk("grant_wait", 32'(w), 32'd1);
    chk("gnt", 32'(GNT), 32'(oh));
    chk("ch_sel", 32'(CH_SEL), 32'(ch));
    chk("done_low_at_grant", 32'(DONE), 32'd0);
    chk("clr_low_at_grant", 32'(CNT_CLR), 32'd0);
    if (!hold) REQ = 4'b0000;
    WINDOW = win_after;
  endtask

  // Follows a granted measurement to its DONE pulse, counting controls.
  task automatic finish_meas(input logic [1:0] ch, input int gate);
    int n, clr_n, clr_first, gate_n, gate_first, done_at, ovl, abt;
    n = 0; clr_n = 0; clr_first = 0; gate_n = 0; gate_first = 0;
    done_at = 0; ovl = 0; abt = 0;
    while (done_at == 0 && n < gate + SETTLE + 20) begin
      @(posedge REF_CLK); #1;
      n++;
      if (CNT_CLR) begin
        if (clr_n == 0) clr_first = n;
        clr_n++;
      end
      if (CNT_GATE) begin
        if (gate_n == 0) gate_first = n;
        gate_n++;
      end
      if (CNT_CLR && CNT_GATE) ovl++;
      if (ABORTED) abt++;
      if (DONE) done_at = n;
    end
    chk("clr_count", 32'(clr_n), 32'd1);
    chk("clr_first", 32'(clr_first), 32'd1);
    chk("gate_first", 32'(gate_first), 32'd2);
    chk("gate_len", 32'(gate_n), 32'(gate));
    chk("done_latency", 32'(done_at), 32'(gate + SETTLE + 2));
    chk("done_ch", 32'(DONE_CH), 32'(ch));
    chk("gnt_clear_at_done", 32'(GNT), 32'd0);
    chk("busy_clear_at_done", 32'(BUSY), 32'd0);
    chk("clr_gate_overlap", 32'(ovl), 32'd0);
    chk("no_abort", 32'(abt), 32'd0);
  endtask

  task automatic run_meas(input logic [3:0] req, input logic [15:0] win,
                          input logic [15:0] win_after, input logic [1:0] ch,
                          input int gate);
    do_grant(req, win, win_after, ch, 1'b0);
    finish_meas(ch, gate);
  endtask

  task automatic reset_pulse();
    OPB_RST = 1'b1;
    #2;
    OPB_RST = 1'b0;
    @(posedge REF_CLK); #1;
  endtask

  initial begin
    int n, gate_n;
    OPB_RST = 1'b1;
    REQ = 4'b0000;
    WINDOW = 16'd0;
    ABORT = 1'b0;

    vecs[0] = '{4'b0010, 16'd10,     16'd3,  2'd1, 10};
    vecs[1] = '{4'b1111, 16'd2,      16'd9,  2'd2, 2};
    vecs[2] = '{4'b1111, 16'd2,      16'd0,  2'd3, 2};
    vecs[3] = '{4'b1111, 16'd2,      16'd7,  2'd0, 2};
    vecs[4] = '{4'b0001, 16'd0,      16'd12, 2'd0, 1};
    vecs[5] = '{4'b1100, 16'd3,      16'd1,  2'd2, 3};
    vecs[6] = '{4'b0101, 16'd1,      16'd4,  2'd0, 1};
    vecs[7] = '{4'b1111, 16'hFFFF,   16'd2,  2'd1, 65535};
    vecs[8] = '{4'b0100, 16'd5,      16'd20, 2'd2, 5};

    #12;
    check_zero("reset");
    OPB_RST = 1'b0;
    @(posedge REF_CLK); #1;
    check_zero("post_reset");

    // Table of independent measurements; pointer carries between entries.
    for (int i = 0; i < 9; i++) begin
      run_meas(vecs[i].req, vecs[i].win, vecs[i].win_after, vecs[i].ch, vecs[i].gate);
    end

    // Held requests on every channel: strict 0,1,2,3,0 with one idle cycle between.
    reset_pulse();
    for (int i = 0; i < 5; i++) begin
      do_grant(4'b1111, 16'd2, 16'd2, 2'(i % 4), (i < 4));
      finish_meas(2'(i % 4), 2);
    end
    run_meas(4'b1000, 16'd2, 16'd2, 2'd3, 2);

    // Abort channel 0 in its third gate cycle; channel 3 must be next.
    do_grant(4'b1001, 16'd10, 16'd10, 2'd0, 1'b1);
    n = 0; gate_n = 0;
    while (gate_n < 3 && n < 10) begin
      @(posedge REF_CLK); #1;
      n++;
      if (CNT_GATE) gate_n++;
    end
    chk("abort_pre_gate", 32'(CNT_GATE), 32'd1);
    ABORT = 1'b1;
    @(posedge REF_CLK); #1;
    ABORT = 1'b0;
    chk("abort_gate_low", 32'(CNT_GATE), 32'd0);
    chk("abort_pulse", 32'(ABORTED), 32'd1);
    chk("abort_gnt", 32'(GNT), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_no_done", 32'(DONE), 32'd0);
    chk("abort_done_ch", 32'(DONE_CH), 32'd3);
    @(posedge REF_CLK); #1;
    chk("abort_pulse_end", 32'(ABORTED), 32'd0);
    chk("after_abort_gnt", 32'(GNT), 32'b1000);
    chk("after_abort_ch", 32'(CH_SEL), 32'd3);
    chk("after_abort_no_done", 32'(DONE), 32'd0);
    REQ = 4'b0000;

    // Asynchronous reset in the middle of the channel 3 gate window.
    @(posedge REF_CLK); #1;
    @(posedge REF_CLK); #1;
    chk("pre_reset_gate", 32'(CNT_GATE), 32'd1);
    #2;
    OPB_RST = 1'b1;
    #1;
    check_zero("async_reset");
    #2;
    OPB_RST = 1'b0;
    run_meas(4'b0011, 16'd4, 16'd4, 2'd0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/osc_meas_scheduler.md
# osc_meas_scheduler

Round-robin measurement scheduler that shares the single gated timer counter of the oscillator-counter block among NCH oscillator-measurement requesters. It runs entirely in the REF_CLK domain. For each measurement it selects one requester, clears the shared counter, opens the counter gate for a programmed number of REF_CLK cycles, waits for the SYSCLK-domain count to settle, and then reports completion for that channel.

## Interface
Parameters:
- NCH, 4, number of requesters (2..8)
- CH_W, 2, width of channel index; must equal clog2(NCH)
- SETTLE, 3, REF_CLK cycles held after gate close before reporting (1..15)

Ports:
- REF_CLK  in  1  measurement reference clock; all logic on rising edge
- OPB_RST  in  1  reset, asynchronous, active-high
- REQ  in  NCH  level request per channel; driven synchronous to REF_CLK
- WINDOW  in  16  gate length in REF_CLK cycles; sampled at grant
- ABORT  in  1  synchronous abort of the current measurement
- GNT  out  NCH  one-hot grant, high from CLEAR through REPORT
- CH_SEL  out  CH_W  binary index of the granted channel; drives the oscillator mux
- CNT_CLR  out  1  counter clear, one cycle
- CNT_GATE  out  1  counter enable window
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle completion pulse
- DONE_CH  out  CH_W  channel of the last completed measurement; holds until the next DONE
- ABORTED  out  1  one-cycle pulse when a measurement is abandoned

## Operation
- All outputs are registered.
- Reset values: GNT=0, CH_SEL=0, CNT_CLR=0, CNT_GATE=0, BUSY=0, DONE=0, DONE_CH=0, ABORTED=0. Round-robin pointer = 0, state = IDLE.
- State IDLE:
  - If REQ≠0, pick the first set bit searching upward from the pointer, wrapping modulo NCH.
  - Load GNT/CH_SEL with that channel, latch WINDOW into wlen (WINDOW=0 latched as 1), go to CLEAR.
  - If REQ=0, stay in IDLE.
- State CLEAR (1 cycle): CNT_CLR=1, go to GATE.
- State GATE: CNT_GATE=1. A down-counter loaded with wlen decrements each cycle. When it reaches 1, go to SETTLE.
- State SETTLE: CNT_GATE=0. Hold SETTLE cycles, then go to REPORT.
- State REPORT (1 cycle): DONE=1, DONE_CH=CH_SEL, pointer = granted channel + 1 (mod NCH). Next state is IDLE; GNT clears on entry to IDLE.
- REQ deassertion after grant is ignored: the measurement completes and DONE is still pulsed.
- ABORT in CLEAR/GATE/SETTLE:
  - Next cycle: state = IDLE, CNT_GATE=0, GNT=0, ABORTED=1 for one cycle.
  - DONE is not pulsed and DONE_CH is unchanged. The pointer advances past the aborted channel.
- ABORT in IDLE or REPORT: ignored (REPORT completes normally).
- WINDOW changes while busy do not affect the current measurement.
- Reset mid-operation: all outputs return to reset values immediately, asynchronously, including a CNT_GATE that was high.

## Timing
- REQ seen at edge k in IDLE:
  - GNT/CH_SEL/BUSY high after edge k.
  - CNT_CLR high for edge k+1..k+2.
  - CNT_GATE high for exactly wlen cycles starting at edge k+2.
  - DONE high for one cycle starting at edge k+2+wlen+SETTLE.
- Grant-to-DONE latency: wlen+SETTLE+2 cycles.
- Minimum REQ-to-next-grant gap: back-to-back requests have one IDLE cycle between REPORT and the next CLEAR.
- CNT_CLR and CNT_GATE are never high in the same cycle.
- At most one GNT bit is high at any time; GNT=0 whenever BUSY=0.
- Pointer wrap: after channel NCH-1 completes, the pointer is 0.

## Test plan
- Reset then REQ=4'b0010, WINDOW=10 → GNT=0010, CH_SEL=1, one CNT_CLR, CNT_GATE high exactly 10 cycles, DONE after 15 cycles from grant, DONE_CH=1.
- REQ=4'b1111 held, WINDOW=2 → grants in order 0,1,2,3,0. Each DONE_CH matches the grant; one IDLE cycle between measurements.
- WINDOW=0 → CNT_GATE high exactly 1 cycle. WINDOW=16'hFFFF → high exactly 65535 cycles.
- REQ=4'b1001, channel 0 ABORTed in GATE cycle 3 → CNT_GATE low next cycle, ABORTED pulse, no DONE, next grant is channel 3.
- REQ=4'b0100 pulsed for one cycle, then WINDOW changed 5→20 during GATE → gate lasts 5 cycles, DONE_CH=2.
- OPB_RST asserted mid-GATE → all outputs 0 immediately. After release with REQ=4'b0001 → channel 0 granted (pointer reset).
